// File: rtl/led_pkg.sv
// Shared encodings for the LED matrix controller: display modes, scan FSM states
// and a counter-width helper.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL  = 2'd0,
        MODE_REVERSE = 2'd1,
        MODE_TEST    = 2'd2,
        MODE_STOP    = 2'd3
    } led_mode_e;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } led_state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_slot.sv
// PWM timebase: divides the clock into TICK_DIV-clock slots and counts slots
// 0..2^GRAY_BITS-1 while run_i is high; both counters clear while idle.
module led_pwm_slot
    import led_pkg::*;
#(
    parameter int unsigned GRAY_BITS = 3,
    parameter int unsigned TICK_DIV  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_i,
    output logic [GRAY_BITS-1:0] slot_nxt_o,
    output logic                 last_o
);

    localparam int unsigned TW = cnt_width(TICK_DIV);

    logic [TW-1:0]        tick_q, tick_d;
    logic [GRAY_BITS-1:0] slot_q, slot_d;
    logic                 tick_last;

    always_comb begin
        tick_last = (tick_q == TW'(TICK_DIV - 1));
        tick_d    = '0;
        slot_d    = '0;
        if (run_i) begin
            tick_d = tick_last ? '0 : tick_q + TW'(1);
            slot_d = tick_last ? slot_q + GRAY_BITS'(1) : slot_q;
        end
    end

    assign last_o     = run_i && tick_last && (slot_q == '1);
    assign slot_nxt_o = slot_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
            slot_q <= '0;
        end else begin
            tick_q <= tick_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/led_matrix_ctrl.sv
// Double-buffered red/green LED matrix scanner with PWM gray levels and row blanking.
// Define LED_BRIGHTNESS_EN to add the 'bright' input that caps the displayed level.
module led_matrix_ctrl
    import led_pkg::*;
#(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned COLS      = 8,
    parameter int unsigned GRAY_BITS = 3,
    parameter int unsigned TICK_DIV  = 4,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               mode,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [$clog2(ROWS)-1:0]  wr_row,
    input  logic [$clog2(COLS)-1:0]  wr_col,
    input  logic [GRAY_BITS-1:0]     wr_r,
    input  logic [GRAY_BITS-1:0]     wr_g,
`ifdef LED_BRIGHTNESS_EN
    input  logic [GRAY_BITS-1:0]     bright,
`endif
    input  logic                     swap_req,
    output logic                     swap_done,
    output logic                     frame_start,
    output logic [ROWS-1:0]          output_row,
    output logic [COLS-1:0]          output_col_r,
    output logic [COLS-1:0]          output_col_g
);

    localparam int unsigned RW   = $clog2(ROWS);
    localparam int unsigned NPIX = ROWS * COLS;
    localparam int unsigned IW   = cnt_width(NPIX);
    localparam int unsigned PW   = 2 * GRAY_BITS;
    localparam int unsigned BW   = cnt_width(BLANK_CYC);
    localparam int unsigned LMAX = (2 ** GRAY_BITS) - 1;

    led_state_e           state_q, state_d;
    led_mode_e            mode_q, mode_d;
    logic [RW-1:0]        row_q, row_d;
    logic [BW-1:0]        blank_q, blank_d;
    logic                 front_q, front_d;
    logic                 pend_q, pend_d;
    logic                 frame_odd_q, frame_odd_d;
    logic                 fs_q, fs_d;
    logic                 done_q, done_d;
    logic                 rdy_q;
    logic [ROWS-1:0]      out_row_q, out_row_d;
    logic [COLS-1:0]      col_r_q, col_r_d;
    logic [COLS-1:0]      col_g_q, col_g_d;

    logic [PW-1:0]        fb_q [2][NPIX];
    logic [IW-1:0]        wr_idx;
    logic                 wr_fire;
    logic [GRAY_BITS-1:0] slot_nxt;
    logic                 pwm_last;
    logic [PW-1:0]        pix;
    logic [GRAY_BITS-1:0] lvl_r, lvl_g;

    led_pwm_slot #(
        .GRAY_BITS (GRAY_BITS),
        .TICK_DIV  (TICK_DIV)
    ) u_pwm (
        .clk        (clk),
        .rst        (rst),
        .run_i      (state_q == ST_DRIVE),
        .slot_nxt_o (slot_nxt),
        .last_o     (pwm_last)
    );

    assign wr_idx  = IW'(wr_row) * IW'(COLS) + IW'(wr_col);
    assign wr_fire = wr_valid && rdy_q && (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);

    // Scan FSM: STOP overrides everything; mode and buffer swap commit only at BLANK exit.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        blank_d     = blank_q;
        mode_d      = mode_q;
        front_d     = front_q;
        pend_d      = pend_q | swap_req;
        frame_odd_d = frame_odd_q;
        fs_d        = 1'b0;
        done_d      = 1'b0;
        if (led_mode_e'(mode) == MODE_STOP) begin
            state_d = ST_BLANK;
            row_d   = RW'(ROWS - 1);
            blank_d = '0;
        end else begin
            unique case (state_q)
                ST_BLANK: begin
                    if (blank_q == BW'(BLANK_CYC - 1)) begin
                        state_d = ST_DRIVE;
                        blank_d = '0;
                        row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
                        mode_d  = led_mode_e'(mode);
                        if (row_d == '0) begin
                            fs_d = 1'b1;
                            if (pend_q) begin
                                front_d = ~front_q;
                                pend_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end
                    end else begin
                        blank_d = blank_q + BW'(1);
                    end
                end
                ST_DRIVE: begin
                    if (pwm_last) begin
                        state_d = ST_BLANK;
                        if (row_q == RW'(ROWS - 1)) frame_odd_d = ~frame_odd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pin values are derived from next-state so they line up with the FSM edge.
    always_comb begin
        out_row_d = '1;
        col_r_d   = '0;
        col_g_d   = '0;
        pix       = '0;
        lvl_r     = '0;
        lvl_g     = '0;
        if (state_d == ST_DRIVE) begin
            out_row_d[row_d] = 1'b0;
            for (int c = 0; c < COLS; c++) begin
                pix   = fb_q[front_d][IW'(row_d) * IW'(COLS) + IW'(c)];
                lvl_r = pix[PW-1:GRAY_BITS];
                lvl_g = pix[GRAY_BITS-1:0];
                unique case (mode_d)
                    MODE_REVERSE: begin
                        lvl_r = GRAY_BITS'(LMAX) - lvl_r;
                        lvl_g = GRAY_BITS'(LMAX) - lvl_g;
                    end
                    MODE_TEST: begin
                        lvl_r = frame_odd_q ? '0 : GRAY_BITS'(LMAX);
                        lvl_g = frame_odd_q ? GRAY_BITS'(LMAX) : '0;
                    end
                    default: ;
                endcase
`ifdef LED_BRIGHTNESS_EN
                if (bright < lvl_r) lvl_r = bright;
                if (bright < lvl_g) lvl_g = bright;
`endif
                col_r_d[c] = (slot_nxt < lvl_r);
                col_g_d[c] = (slot_nxt < lvl_g);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_BLANK;
            mode_q      <= MODE_NORMAL;
            row_q       <= RW'(ROWS - 1);
            blank_q     <= '0;
            front_q     <= 1'b0;
            pend_q      <= 1'b0;
            frame_odd_q <= 1'b0;
            fs_q        <= 1'b0;
            done_q      <= 1'b0;
            rdy_q       <= 1'b1;
            out_row_q   <= '1;
            col_r_q     <= '0;
            col_g_q     <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            row_q       <= row_d;
            blank_q     <= blank_d;
            front_q     <= front_d;
            pend_q      <= pend_d;
            frame_odd_q <= frame_odd_d;
            fs_q        <= fs_d;
            done_q      <= done_d;
            rdy_q       <= ~pend_d;
            out_row_q   <= out_row_d;
            col_r_q     <= col_r_d;
            col_g_q     <= col_g_d;
        end
    end

    // Pixel store {red, green}; writes always target the back buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < NPIX; i++) fb_q[b][i] <= '0;
            end
        end else if (wr_fire) begin
            fb_q[~front_q][wr_idx] <= {wr_r, wr_g};
        end
    end

    assign wr_ready     = rdy_q;
    assign swap_done    = done_q;
    assign frame_start  = fs_q;
    assign output_row   = out_row_q;
    assign output_col_r = col_r_q;
    assign output_col_g = col_g_q;

endmodule

// File: tb/tb_led_matrix_ctrl.sv
// Self-checking bench for led_matrix_ctrl at default parameters (8x8, 3-bit gray,
// DRIVE 32 clocks, row period 34, frame 272); LED_BRIGHTNESS_EN adds the clamp test.
module tb_led_matrix_ctrl;
    import led_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_row;
    logic [2:0] wr_col;
    logic [2:0] wr_r;
    logic [2:0] wr_g;
`ifdef LED_BRIGHTNESS_EN
    logic [2:0] bright;
`endif
    logic       swap_req;
    logic       swap_done;
    logic       frame_start;
    logic [7:0] output_row;
    logic [7:0] output_col_r;
    logic [7:0] output_col_g;

    always #5 clk = ~clk;

    led_matrix_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .wr_r         (wr_r),
        .wr_g         (wr_g),
`ifdef LED_BRIGHTNESS_EN
        .bright       (bright),
`endif
        .swap_req     (swap_req),
        .swap_done    (swap_done),
        .frame_start  (frame_start),
        .output_row   (output_row),
        .output_col_r (output_col_r),
        .output_col_g (output_col_g)
    );

    typedef struct {
        int         row;
        int         col;
        int         r;
        int         g;
        logic [1:0] md;
        int         exp_r;
        int         exp_g;
    } vec_t;

    typedef struct {
        string tag;
        int    r_on;
        int    g_on;
        int    len;
    } exp_t;

    vec_t vecs[7];
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic do_reset(input logic [1:0] md);
        @(negedge clk);
        rst      = 1'b1;
        mode     = md;
        wr_valid = 1'b0;
        swap_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_px(input int row, input int col, input int r, input int g,
                            input logic with_swap);
        wr_row   = 3'(row);
        wr_col   = 3'(col);
        wr_r     = 3'(r);
        wr_g     = 3'(g);
        wr_valid = 1'b1;
        swap_req = with_swap;
        @(negedge clk);
        wr_valid = 1'b0;
        swap_req = 1'b0;
    endtask

    task automatic wait_swap_done(input string tag);
        int k = 0;
        while (!swap_done && k < 700) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_swap_done"}, int'(swap_done), 1);
        chk({tag, "_swap_on_frame_start"}, int'(frame_start), 1);
    endtask

    // Waits for the row's drive window, then counts on-clocks of one column over it.
    task automatic measure(input string tag, input int row, input int col,
                           output int r_on, output int g_on, output int len);
        logic [7:0] tgt;
        int k = 0;
        tgt  = ~(8'd1 << row);
        r_on = 0;
        g_on = 0;
        len  = 0;
        while (output_row != tgt && k < 700) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_row_reached"}, int'(k < 700), 1);
        while (output_row == tgt && len < 64) begin
            len++;
            if (output_col_r[col]) r_on++;
            if (output_col_g[col]) g_on++;
            @(negedge clk);
        end
    endtask

    task automatic check_sb(input int r_on, input int g_on, input int len);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, "_r_on"}, r_on, e.r_on);
            chk({e.tag, "_g_on"}, g_on, e.g_on);
            chk({e.tag, "_drive_len"}, len, e.len);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int k;
        int r_on, g_on, len;
        int ready_seen;

        vecs[0] = '{3, 5, 3, 0, MODE_NORMAL,  12,  0};
        vecs[1] = '{3, 5, 7, 0, MODE_REVERSE,  0, 28};
        vecs[2] = '{3, 5, 0, 0, MODE_REVERSE, 28, 28};
        vecs[3] = '{0, 0, 7, 7, MODE_NORMAL,  28, 28};
        vecs[4] = '{7, 7, 1, 6, MODE_NORMAL,   4, 24};
        vecs[5] = '{5, 2, 4, 2, MODE_REVERSE, 12, 20};
        vecs[6] = '{1, 6, 0, 5, MODE_NORMAL,   0, 20};

        rst      = 1'b1;
        mode     = MODE_NORMAL;
        wr_valid = 1'b0;
        wr_row   = '0;
        wr_col   = '0;
        wr_r     = '0;
        wr_g     = '0;
        swap_req = 1'b0;
`ifdef LED_BRIGHTNESS_EN
        bright   = 3'd7;
`endif

        // Reset state and frame cadence.
        repeat (3) @(negedge clk);
        chk("reset_output_row", int'(output_row), 8'hFF);
        chk("reset_col_r", int'(output_col_r), 0);
        chk("reset_col_g", int'(output_col_g), 0);
        chk("reset_wr_ready", int'(wr_ready), 1);
        chk("reset_frame_start", int'(frame_start), 0);
        chk("reset_swap_done", int'(swap_done), 0);
        rst = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < 700);
        chk("first_frame_start_delay", k, 2);
        chk("first_frame_row0", int'(output_row), 8'hFE);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < 700);
        chk("frame_period", k, 272);

        // Table-driven pixel writes, each displayed after a buffer swap.
        for (int i = 0; i < 7; i++) begin
            mode = vecs[i].md;
            write_px(vecs[i].row, vecs[i].col, vecs[i].r, vecs[i].g, 1'b1);
            sb_q.push_back('{$sformatf("vec%0d", i), vecs[i].exp_r, vecs[i].exp_g, 32});
            wait_swap_done($sformatf("vec%0d", i));
            measure($sformatf("vec%0d", i), vecs[i].row, vecs[i].col, r_on, g_on, len);
            check_sb(r_on, g_on, len);
        end

        // Swap pending mid-frame blocks writes until the swap lands.
        do_reset(MODE_NORMAL);
        write_px(2, 2, 5, 0, 1'b1);
        wait_swap_done("blk_first");
        repeat (50) @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        chk("blk_wr_ready_low", int'(wr_ready), 0);
        wr_row = 3'd2;
        wr_col = 3'd2;
        wr_r   = 3'd1;
        wr_g   = 3'd3;
        ready_seen = 0;
        k = 0;
        while (!swap_done && k < 700) begin
            if (wr_ready) ready_seen++;
            wr_valid = (k < 5);
            swap_req = (k == 20);
            @(negedge clk);
            k++;
        end
        wr_valid = 1'b0;
        swap_req = 1'b0;
        chk("blk_ready_held_low", ready_seen, 0);
        chk("blk_swap_done", int'(swap_done), 1);
        chk("blk_ready_at_swap_done", int'(wr_ready), 1);
        @(negedge clk);
        chk("blk_repeat_absorbed", int'(wr_ready), 1);
        sb_q.push_back('{"blk_not_stored", 0, 0, 32});
        measure("blk_not_stored", 2, 2, r_on, g_on, len);
        check_sb(r_on, g_on, len);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        sb_q.push_back('{"blk_swap_back", 20, 0, 32});
        wait_swap_done("blk_back");
        measure("blk_swap_back", 2, 2, r_on, g_on, len);
        check_sb(r_on, g_on, len);

        // STOP mid-row, then restart at row 0.
        k = 0;
        while (output_row != 8'hEF && k < 700) begin
            @(negedge clk);
            k++;
        end
        repeat (10) @(negedge clk);
        chk("stop_row_active_before", int'(output_row), 8'hEF);
        mode = MODE_STOP;
        @(negedge clk);
        chk("stop_row_off", int'(output_row), 8'hFF);
        chk("stop_col_r_off", int'(output_col_r), 0);
        chk("stop_col_g_off", int'(output_col_g), 0);
        repeat (20) @(negedge clk);
        chk("stop_held_off", int'(output_row), 8'hFF);
        mode = MODE_NORMAL;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < 700);
        chk("stop_restart_delay", k, 2);
        chk("stop_restart_row0", int'(output_row), 8'hFE);

        // TEST mode alternates red-only and green-only frames.
        do_reset(MODE_TEST);
        sb_q.push_back('{"test_even", 28, 0, 32});
        measure("test_even", 0, 0, r_on, g_on, len);
        check_sb(r_on, g_on, len);
        sb_q.push_back('{"test_odd", 0, 28, 32});
        measure("test_odd", 0, 3, r_on, g_on, len);
        check_sb(r_on, g_on, len);

`ifdef LED_BRIGHTNESS_EN
        // Brightness cap.
        do_reset(MODE_NORMAL);
        bright = 3'd2;
        write_px(1, 4, 7, 1, 1'b1);
        sb_q.push_back('{"bright", 8, 4, 32});
        wait_swap_done("bright");
        measure("bright", 1, 4, r_on, g_on, len);
        check_sb(r_on, g_on, len);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/led_matrix_ctrl.md
LED_MATRIX_CTRL -- requirements
Module: led_matrix_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 8, number of matrix rows (>=2).
REQ-002 SHALL have parameter COLS, default 8, number of matrix columns (>=2).
REQ-003 SHALL have parameter GRAY_BITS, default 3, gray-level bits per colour channel (1..8).
REQ-004 SHALL have parameter TICK_DIV, default 4, clocks per PWM slot (>=1).
REQ-005 SHALL have parameter BLANK_CYC, default 2, anti-ghost blanking clocks between rows (>=1).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port mode, input, 2, 0 NORMAL, 1 REVERSE, 2 TEST, 3 STOP.
REQ-009 SHALL have ports wr_valid/wr_ready, input/output, 1 each, pixel-write handshake.
REQ-010 SHALL have ports wr_row/wr_col, input, clog2(ROWS)/clog2(COLS), write address.
REQ-011 SHALL have ports wr_r/wr_g, input, GRAY_BITS each, red/green gray level.
REQ-012 SHALL have ports swap_req (input, 1) and swap_done (output, 1), buffer-swap request/ack pulse.
REQ-013 SHALL have port frame_start, output, 1, one-clock pulse at start of row 0 drive.
REQ-014 SHALL have ports output_row (ROWS, active-low), output_col_r and output_col_g (COLS, active-high).

Function
REQ-015 SHALL hold two frame buffers (front displayed, back written), ROWS*COLS pixels of 2*GRAY_BITS bits each.
REQ-016 SHALL accept a write when wr_valid & wr_ready; data lands in back buffer; out-of-range addresses are ignored.
REQ-017 SHALL scan with FSM BLANK -> DRIVE -> BLANK: DRIVE lasts 2^GRAY_BITS*TICK_DIV clocks, BLANK lasts BLANK_CYC clocks.
REQ-018 SHALL advance the row index at BLANK exit, wrapping ROWS-1 -> 0; frame_start pulses on the first DRIVE clock of row 0.
REQ-019 SHALL drive pixel channel on during PWM slot s (0..2^GRAY_BITS-1) iff s < effective level; level 0 never on.
REQ-020 SHALL in DRIVE assert only output_row[row]=0; in BLANK all rows 1 and all columns 0.
REQ-021 SHALL use effective level = pixel level in NORMAL, (2^GRAY_BITS-1)-level in REVERSE.
REQ-022 SHALL in TEST show every pixel at full level, red-only on even frames, green-only on odd frames.
REQ-023 SHALL in STOP force all outputs off the next clock and hold the FSM in BLANK with row ROWS-1.
REQ-024 SHALL apply changes among NORMAL/REVERSE/TEST only at a row boundary; leaving STOP restarts at row 0 with frame_start after BLANK_CYC clocks.
REQ-025 SHALL latch swap_req as pending; drop wr_ready while pending; swap front/back and pulse swap_done on the frame_start cycle.
REQ-026 SHALL accept a write coinciding with swap_req (write first, then pending); repeated swap_req while pending is absorbed.
REQ-027 SHALL register all outputs (one clock from internal state to pins).

Reset
REQ-028 SHALL on rst: both buffers zero, FSM BLANK, row ROWS-1, counters 0, pending cleared, output_row all 1, columns 0, wr_ready 1, pulses 0.
REQ-029 SHALL let rst mid-frame abort immediately; the pending swap is lost.

Configuration
REQ-030 SHALL with LED_BRIGHTNESS_EN defined add input bright (GRAY_BITS) and use min(effective level, bright); without it no port, no clamp.

Structure
REQ-031 SHALL place mode encodings and FSM state encodings in shared package led_pkg.
REQ-032 SHALL implement tick divider plus slot counter as sub-module led_pwm_slot.

Verification (defaults: DRIVE 32 clocks, row period 34, frame 272)
REQ-033 SHALL check reset: output_row=FF, cols=00, wr_ready=1, first frame_start 2 clocks after rst release, then every 272.
REQ-034 SHALL check write (3,5,r=3,g=0) + swap_req: swap_done at next frame_start; in row 3 drive output_row=F7, col_r[5] high 12 of 32 clocks, col_g 0.
REQ-035 SHALL check REVERSE: r=7 gives 0 on-clocks; r=0 gives 28 on-clocks.
REQ-036 SHALL check swap_req mid-frame: wr_ready low until swap_done; write offered while low is not stored.
REQ-037 SHALL check STOP mid-row: outputs off next clock; return to NORMAL gives frame_start 2 clocks later at row 0.
REQ-038 SHALL check with LED_BRIGHTNESS_EN, bright=2, r=7: col_r on 8 of 32 clocks.
